div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_pkg.sv | 16 +
 rtl/div_arbiter_if.sv | 29 ++
 rtl/div_iter_core.sv | 69 ++++++
 rtl/div_arbiter.sv | 133 +++++++++++++
 tb/tb_div_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and defaults for the two-requester divider arbiter.
// Holds the FSM encoding, width defaults and requester-id type.
package div_pkg;

  localparam int DIV_DW = 16;
  localparam int DIV_BW = 8;

  typedef logic req_id_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_arbiter_if.sv
// Request/response bundle between requesters and the divider arbiter.
// master = requester/consumer side, slave = arbiter side.
interface div_arbiter_if #(
  parameter int DW = 16,
  parameter int BW = 8
);
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*DW-1:0] req_a;
  logic [2*BW-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic            resp_id;
  logic [DW-1:0]   resp_quot;
  logic [DW-1:0]   resp_rem;
  logic            resp_divz;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id,
    input  resp_quot, resp_rem, resp_divz
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id,
    output resp_quot, resp_rem, resp_divz
  );
endinterface

// File: rtl/div_iter_core.sv
// Iterative restoring divider, one quotient bit per cycle, MSB first.
// done is high in the last iteration cycle; quot/rem show that result.
module div_iter_core
  import div_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int BW = DIV_BW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [BW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quot,
  output logic [DW-1:0] rem
);
  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0] sh_q;
  logic [BW-1:0] rem_q;
  logic [BW-1:0] b_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  logic [BW:0]   trial;
  logic          fit;
  logic [BW-1:0] rem_nxt;
  logic [DW-1:0] sh_nxt;

  // Partial remainder stays below b, so BW bits plus one shifted-in bit suffice.
  always_comb begin
    trial   = {rem_q, sh_q[DW-1]};
    fit     = trial >= {1'b0, b_q};
    rem_nxt = trial[BW-1:0];
    if (fit)
      rem_nxt = BW'(trial - {1'b0, b_q});
    sh_nxt  = {sh_q[DW-2:0], fit};
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(1));
  assign quot = sh_nxt;
  assign rem  = DW'(rem_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      rem_q  <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      sh_q   <= a;
      rem_q  <= '0;
      b_q    <= b;
      cnt_q  <= CW'(DW);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      sh_q   <= sh_nxt;
      rem_q  <= rem_nxt;
      cnt_q  <= cnt_q - CW'(1);
      if (cnt_q == CW'(1))
        busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Two-requester arbiter sharing one iterative divider.
// Define DIV_ARB_RR_EN for round-robin; default is fixed priority (req 0 wins).
module div_arbiter
  import div_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int BW = DIV_BW
) (
  input logic         clk,
  input logic         rst_n,
  div_arbiter_if.slave bus
);
  div_state_e    state_q;
  div_state_e    state_d;
  req_id_t       gnt;
  req_id_t       id_q;
  logic          any_req;
  logic          accept;
  logic          start;
  logic          b_zero;
  logic [1:0]    ready;
  logic [DW-1:0] sel_a;
  logic [BW-1:0] sel_b;

  logic          core_busy;
  logic          core_done;
  logic [DW-1:0] core_quot;
  logic [DW-1:0] core_rem;

  logic          valid_q;
  logic          divz_q;
  logic [DW-1:0] quot_q;
  logic [DW-1:0] rem_q;

  assign any_req = |bus.req_valid;

`ifdef DIV_ARB_RR_EN
  req_id_t rr_q;

  assign gnt = bus.req_valid[rr_q] ? rr_q : ~rr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_q <= 1'b0;
    else if (accept)
      rr_q <= ~gnt;
  end
`else
  assign gnt = ~bus.req_valid[0];
`endif

  assign sel_a  = gnt ? bus.req_a[DW +: DW] : bus.req_a[0 +: DW];
  assign sel_b  = gnt ? bus.req_b[BW +: BW] : bus.req_b[0 +: BW];
  assign b_zero = (sel_b == '0);
  assign accept = |(bus.req_valid & ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = '0;
    start   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req && !core_busy) begin
          ready[gnt] = 1'b1;
          start      = !b_zero;
          state_d    = b_zero ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: if (core_done) state_d = ST_DONE;
      ST_DONE: if (bus.resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Response registers only move on accept, divider finish or handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q    <= 1'b0;
      valid_q <= 1'b0;
      divz_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      if (accept) begin
        id_q <= gnt;
        if (b_zero) begin
          valid_q <= 1'b1;
          divz_q  <= 1'b1;
          quot_q  <= '0;
          rem_q   <= sel_a;
        end
      end
      if (state_q == ST_BUSY && core_done) begin
        valid_q <= 1'b1;
        divz_q  <= 1'b0;
        quot_q  <= core_quot;
        rem_q   <= core_rem;
      end
      if (state_q == ST_DONE && bus.resp_ready)
        valid_q <= 1'b0;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = valid_q;
  assign bus.resp_id    = id_q;
  assign bus.resp_quot  = quot_q;
  assign bus.resp_rem   = rem_q;
  assign bus.resp_divz  = divz_q;

  div_iter_core #(
    .DW (DW),
    .BW (BW)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (sel_a),
    .b     (sel_b),
    .busy  (core_busy),
    .done  (core_done),
    .quot  (core_quot),
    .rem   (core_rem)
  );

endmodule

// File: tb/tb_div_arbiter.sv
// Directed self-checking bench for div_arbiter.
// Expected results come from hand values and the bench's own a/b, a%b.
module tb_div_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  div_arbiter_if bus ();

  div_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input int id,
                         input logic [15:0] a,
                         input logic [7:0] b);
    bus.req_a[id*16 +: 16] = a;
    bus.req_b[id*8 +: 8]   = b;
    bus.req_valid[id]      = 1'b1;
  endtask

  // Present on one requester, drop valid after the accept edge, wait for resp.
  task automatic run_op(input int id,
                        input logic [15:0] a,
                        input logic [7:0] b,
                        output int n);
    present(id, a, b);
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'(2'b01 << id));
    @(negedge clk);
    n = 1;
    bus.req_valid = 2'b00;
    while (!bus.resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic handshake();
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("resp_valid_clr", 32'(bus.resp_valid), 32'd0);
    bus.resp_ready = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_id"}, 32'(bus.resp_id), 32'd0);
    chk({tag, "_quot"}, 32'(bus.resp_quot), 32'd0);
    chk({tag, "_rem"}, 32'(bus.resp_rem), 32'd0);
    chk({tag, "_divz"}, 32'(bus.resp_divz), 32'd0);
  endtask

  initial begin
    int n;
    int exp_id;
    logic [15:0] va [8];
    logic [7:0]  vb [8];
    int          vid [8];

    bus.req_valid  = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1000 / 7 on requester 0
    run_op(0, 16'd1000, 8'd7, n);
    chk("lat_1000_7", 32'(n), 32'd17);
    chk("quot_1000_7", 32'(bus.resp_quot), 32'd142);
    chk("rem_1000_7", 32'(bus.resp_rem), 32'd6);
    chk("id_1000_7", 32'(bus.resp_id), 32'd0);
    chk("divz_1000_7", 32'(bus.resp_divz), 32'd0);
    handshake();

    // Divide by zero on requester 1
    run_op(1, 16'h1234, 8'd0, n);
    chk("lat_divz", 32'(n), 32'd1);
    chk("quot_divz", 32'(bus.resp_quot), 32'd0);
    chk("rem_divz", 32'(bus.resp_rem), 32'h1234);
    chk("divz_flag", 32'(bus.resp_divz), 32'd1);
    chk("id_divz", 32'(bus.resp_id), 32'd1);
    handshake();

    // Both requesters contending with an always-ready consumer
    present(0, 16'd100, 8'd3);
    present(1, 16'd200, 8'd9);
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!bus.resp_valid && n < 60) begin
        @(negedge clk);
        n++;
      end
`ifdef DIV_ARB_RR_EN
      exp_id = k % 2;
`else
      exp_id = 0;
`endif
      chk("both_valid_seen", 32'(bus.resp_valid), 32'd1);
      chk("both_id", 32'(bus.resp_id), 32'(exp_id));
      chk("both_quot", 32'(bus.resp_quot),
          exp_id == 0 ? 32'd33 : 32'd22);
      chk("both_rem", 32'(bus.resp_rem),
          exp_id == 0 ? 32'd1 : 32'd2);
      @(negedge clk);
    end
    bus.req_valid  = 2'b00;
    bus.resp_ready = 1'b0;
    @(negedge clk);

    // Backpressure: hold result while requester 1 waits
    run_op(0, 16'd65535, 8'd255, n);
    chk("lat_max", 32'(n), 32'd17);
    present(1, 16'd200, 8'd9);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_quot", 32'(bus.resp_quot), 32'd257);
      chk("hold_rem", 32'(bus.resp_rem), 32'd0);
      chk("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("hs_cycle_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("after_hs_valid", 32'(bus.resp_valid), 32'd0);
    chk("after_hs_ready", 32'(bus.req_ready), 32'd2);
    @(negedge clk);
    bus.req_valid = 2'b00;
    n = 1;
    while (!bus.resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("queued_lat", 32'(n), 32'd17);
    chk("queued_id", 32'(bus.resp_id), 32'd1);
    chk("queued_quot", 32'(bus.resp_quot), 32'd22);
    chk("queued_rem", 32'(bus.resp_rem), 32'd2);
    handshake();

    // Reset during BUSY cycle 8
    present(0, 16'd1000, 8'd7);
    @(negedge clk);
    bus.req_valid = 2'b00;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.resp_valid) n++;
    end
    chk("no_stale_resp", 32'(n), 32'd0);
    run_op(1, 16'd200, 8'd9, n);
    chk("post_rst_lat", 32'(n), 32'd17);
    chk("post_rst_quot", 32'(bus.resp_quot), 32'd22);
    chk("post_rst_rem", 32'(bus.resp_rem), 32'd2);
    chk("post_rst_id", 32'(bus.resp_id), 32'd1);
    handshake();

    // Mixed vectors including edge divisors and zero dividend
    va[0] = 16'd54321; vb[0] = 8'd1;   vid[0] = 0;
    va[1] = 16'd54321; vb[1] = 8'd255; vid[1] = 1;
    va[2] = 16'd0;     vb[2] = 8'd13;  vid[2] = 0;
    va[3] = 16'd6;     vb[3] = 8'd200; vid[3] = 1;
    va[4] = 16'hFFFF;  vb[4] = 8'd1;   vid[4] = 1;
    for (int k = 5; k < 8; k++) begin
      va[k]  = 16'($urandom);
      vb[k]  = 8'($urandom_range(255, 1));
      vid[k] = k % 2;
    end
    for (int k = 0; k < 8; k++) begin
      run_op(vid[k], va[k], vb[k], n);
      chk("vec_lat", 32'(n), 32'd17);
      chk("vec_quot", 32'(bus.resp_quot), 32'(va[k] / 16'(vb[k])));
      chk("vec_rem", 32'(bus.resp_rem), 32'(va[k] % 16'(vb[k])));
      chk("vec_id", 32'(bus.resp_id), 32'(vid[k]));
      chk("vec_divz", 32'(bus.resp_divz), 32'd0);
      handshake();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
